id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus execute-side operand front end for the 64-bit pipelined core.
//  Captures decoded operands and control each cycle, resolves EX/MEM and MEM/WB forwarding,
//  decodes ALUOp/funct into the 4-bit ALU control word, and drives the ALU's A, B and control
//  inputs. Also detects load-use hazards against the instruction currently in decode.
// PARAMETERS
//  XLEN     64  datapath width
//  REG_AW   5   register-index width
// PORTS
//  clk               in   1      rising-edge clock
//  rst_n             in   1      asynchronous, active-low reset
//  stall             in   1      hold all ID/EX contents (external memory stall)
//  flush             in   1      replace ID/EX contents with bubble (branch taken)
//  dec_valid         in   1      decode slot holds a real instruction
//  dec_pc            in   XLEN   PC of decoding instruction
//  dec_rs1_data      in   XLEN   register-file read 1
//  dec_rs2_data      in   XLEN   register-file read 2
//  dec_imm           in   XLEN   sign-extended immediate
//  dec_rs1           in   REG_AW source index 1
//  dec_rs2           in   REG_AW source index 2
//  dec_uses_rs2      in   1      instruction reads rs2 (R-type, store, branch)
//  dec_rd            in   REG_AW destination index
//  dec_ctrl          in   9      {alu_op[1:0],alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch,funct7_b30}
//  dec_funct3        in   3      funct3 field
//  exm_reg_write     in   1      EX/MEM writes back
//  exm_rd            in   REG_AW EX/MEM destination
//  exm_result        in   XLEN   EX/MEM ALU result
//  mwb_reg_write     in   1      MEM/WB writes back
//  mwb_rd            in   REG_AW MEM/WB destination
//  mwb_result        in   XLEN   MEM/WB write-back value
//  load_use_stall    out  1      comb: decode must hold, ID/EX takes bubble next edge
//  ex_valid          out  1      registered valid
//  alu_a             out  XLEN   forwarded rs1 operand
//  alu_b             out  XLEN   alu_src ? imm : forwarded rs2
//  alu_control       out  4      0010 add, 0110 sub, 0000 and, 0001 or, 1111 unsupported
//  ex_store_data     out  XLEN   forwarded rs2 (for stores)
//  ex_pc, ex_imm     out  XLEN   registered PC / immediate
//  ex_rd             out  REG_AW registered destination
//  ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch   out 1 each, gated by ex_valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): every register 0; ex_valid=0; all ex_* controls 0; alu_control=0010; alu_a=alu_b=0.
//  - Edge priority: flush > stall (hold) > load_use_stall (load bubble) > load dec_* (valid=dec_valid).
//  - Bubble: all fields 0, ex_valid=0; alu_op=00 yields add 0+0.
//  - Latency: dec_* visible on ex_*/alu_* one cycle after capture; forwarding and ALU-control decode are combinational.
//  - Forwarding per source (rs1, rs2 independent): EX/MEM if exm_reg_write & exm_rd!=0 & exm_rd==src;
//    else MEM/WB if mwb_reg_write & mwb_rd!=0 & mwb_rd==src; else registered rf data. x0 never forwarded.
//  - ALU control: alu_op 00->0010; 01->0110; 10 (R): f3=000 -> b30?0110:0010, 111->0000, 110->0001, else 1111;
//    11 (I): f3=000->0010 (b30 ignored), 111->0000, 110->0001, else 1111.
//  - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & dec_valid &
//    (ex_rd==dec_rs1 | (dec_uses_rs2 & ex_rd==dec_rs2)); forced 0 while flush=1.
//  - Simultaneous stall & load_use_stall: hold wins, hazard re-evaluated next cycle.
//  - Reset mid-operation: contents discarded immediately; no partial state survives.
// STRUCTURE
//  - Shared package: ALU control codes, alu_op encodings, dec_ctrl field offsets.
//  - One sub-module: ex_forward_unit (one instance per source, returns forwarded value).
// TESTING
//  1 Reset: assert rst_n=0 mid-stream -> ex_valid=0, controls 0, alu_control=0010, alu_a=alu_b=0.
//  2 R sub, b30=1, rs1=5 matching exm_rd=5 (result 100), rs2 data 30 -> alu_a=100, alu_b=30, alu_control=0110.
//  3 rs2=7 matches exm_rd=7 (11) and mwb_rd=7 (22) -> EX/MEM wins: alu_b=11 (alu_src=0), ex_store_data=11.
//  4 ld x3 in EX, decode add x4,x3,x1 -> load_use_stall=1; next cycle ex_valid=0, ex_reg_write=0.
//  5 flush=1 and stall=1 same edge -> bubble loaded; exm_rd=0 with exm_reg_write=1 -> no forward.
//  6 addi f3=000, b30=1, imm=-4, rs1=10 -> alu_b=-4, alu_control=0010; f3=100 under op 10 -> 1111.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module : id_ex_stage_pkg
// Brief  : Shared ALU-control codes, alu_op encodings and dec_ctrl field map
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W     = 9;

  // dec_ctrl = {alu_op[1:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, funct7_b30}
  localparam int c_ctrl_aluop_hi  = 8;
  localparam int c_ctrl_aluop_lo  = 7;
  localparam int c_ctrl_alu_src   = 6;
  localparam int c_ctrl_mem_read  = 5;
  localparam int c_ctrl_mem_write = 4;
  localparam int c_ctrl_reg_write = 3;
  localparam int c_ctrl_mem_to_rg = 2;
  localparam int c_ctrl_branch    = 1;
  localparam int c_ctrl_b30       = 0;

  localparam logic [3:0] c_alu_add   = 4'b0010;
  localparam logic [3:0] c_alu_sub   = 4'b0110;
  localparam logic [3:0] c_alu_and   = 4'b0000;
  localparam logic [3:0] c_alu_or    = 4'b0001;
  localparam logic [3:0] c_alu_unsup = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  function automatic logic [3:0] alu_ctrl_decode(input logic [1:0] op,
                                                 input logic [2:0] f3,
                                                 input logic       b30);
    logic [3:0] res;
    res = c_alu_unsup;
    case (alu_op_e'(op))
      ALUOP_ADD: res = c_alu_add;
      ALUOP_SUB: res = c_alu_sub;
      ALUOP_R, ALUOP_I: begin
        case (f3)
          3'b000:  res = (b30 && op == ALUOP_R) ? c_alu_sub : c_alu_add;
          3'b111:  res = c_alu_and;
          3'b110:  res = c_alu_or;
          default: res = c_alu_unsup;
        endcase
      end
      default: res = c_alu_unsup;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_forward_unit.sv
// ============================================================================
// Module : ex_forward_unit
// Brief  : Selects EX/MEM, MEM/WB or register-file value for one source operand
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic              i_exm_reg_write,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic [XLEN-1:0]   i_exm_result,
  input  logic              i_mwb_reg_write,
  input  logic [REG_AW-1:0] i_mwb_rd,
  input  logic [XLEN-1:0]   i_mwb_result,
  output logic [XLEN-1:0]   o_data
);

  logic w_hit_exm;
  logic w_hit_mwb;

  // x0 is hardwired zero, so a write to it must never shadow the RF value
  assign w_hit_exm = i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == i_src);
  assign w_hit_mwb = i_mwb_reg_write && (i_mwb_rd != '0) && (i_mwb_rd == i_src);

  assign o_data = w_hit_exm ? i_exm_result :
                  w_hit_mwb ? i_mwb_result : i_rf_data;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with forwarding, ALU-control decode and
//          load-use hazard detection
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [XLEN-1:0]   dec_pc,
  input  logic [XLEN-1:0]   dec_rs1_data,
  input  logic [XLEN-1:0]   dec_rs2_data,
  input  logic [XLEN-1:0]   dec_imm,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_uses_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic [2:0]        dec_funct3,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [2:0]        r_funct3;

  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic              w_hazard;

  assign w_hazard = r_valid && r_ctrl[c_ctrl_mem_read] && (r_rd != '0) && dec_valid &&
                    ((r_rd == dec_rs1) || (dec_uses_rs2 && (r_rd == dec_rs2)));
  assign load_use_stall = w_hazard && !flush;

  // Priority: flush bubble, then hold, then load-use bubble, then capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_funct3   <= '0;
    end else if (flush || (!stall && load_use_stall)) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_funct3   <= '0;
    end else if (!stall) begin
      r_valid    <= dec_valid;
      r_pc       <= dec_pc;
      r_rs1_data <= dec_rs1_data;
      r_rs2_data <= dec_rs2_data;
      r_imm      <= dec_imm;
      r_rs1      <= dec_rs1;
      r_rs2      <= dec_rs2;
      r_rd       <= dec_rd;
      r_ctrl     <= dec_ctrl;
      r_funct3   <= dec_funct3;
    end
  end

  ex_forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .i_src           (r_rs1),
    .i_rf_data       (r_rs1_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_rs1)
  );

  ex_forward_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .i_src           (r_rs2),
    .i_rf_data       (r_rs2_data),
    .i_exm_reg_write (exm_reg_write),
    .i_exm_rd        (exm_rd),
    .i_exm_result    (exm_result),
    .i_mwb_reg_write (mwb_reg_write),
    .i_mwb_rd        (mwb_rd),
    .i_mwb_result    (mwb_result),
    .o_data          (w_fwd_rs2)
  );

  assign alu_a         = w_fwd_rs1;
  assign alu_b         = r_ctrl[c_ctrl_alu_src] ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign alu_control   = alu_ctrl_decode(r_ctrl[c_ctrl_aluop_hi:c_ctrl_aluop_lo],
                                         r_funct3, r_ctrl[c_ctrl_b30]);

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_imm        = r_imm;
  assign ex_rd         = r_rd;
  assign ex_mem_read   = r_valid && r_ctrl[c_ctrl_mem_read];
  assign ex_mem_write  = r_valid && r_ctrl[c_ctrl_mem_write];
  assign ex_reg_write  = r_valid && r_ctrl[c_ctrl_reg_write];
  assign ex_mem_to_reg = r_valid && r_ctrl[c_ctrl_mem_to_rg];
  assign ex_branch     = r_valid && r_ctrl[c_ctrl_branch];

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module : tb_id_ex_stage
// Brief  : Directed vector table plus hand-written hazard/stall/reset sequences
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, dec_valid, dec_uses_rs2;
  logic [63:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [8:0]  dec_ctrl;
  logic [2:0]  dec_funct3;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [63:0] exm_result, mwb_result;
  logic        load_use_stall, ex_valid;
  logic [63:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1_data(dec_rs1_data),
    .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm), .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2), .dec_uses_rs2(dec_uses_rs2), .dec_rd(dec_rd),
    .dec_ctrl(dec_ctrl), .dec_funct3(dec_funct3),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  typedef struct {
    logic [63:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [8:0]  ctrl;
    logic [2:0]  f3;
    logic        exm_we; logic [4:0] exm_rd; logic [63:0] exm_res;
    logic        mwb_we; logic [4:0] mwb_rd; logic [63:0] mwb_res;
    logic [63:0] exp_a, exp_b, exp_store;
    logic [3:0]  exp_ctl;
    logic        exp_rw;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic dec_set(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [8:0] ctrl, input logic uses2);
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_ctrl = ctrl;
    dec_uses_rs2 = uses2; dec_funct3 = 3'b000;
    dec_rs1_data = 64'd1; dec_rs2_data = 64'd2; dec_imm = 64'd0; dec_pc = 64'h100;
  endtask

  // ctrl = {op[1:0], src, mr, mw, rw, m2r, br, b30}
  localparam logic [8:0] c_r_add = 9'b10_0_0_0_1_0_0_0;
  localparam logic [8:0] c_r_sub = 9'b10_0_0_0_1_0_0_1;
  localparam logic [8:0] c_ld    = 9'b00_1_1_0_1_1_0_0;

  vec_t vecs[$];

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    dec_set(0, 0, 0, 9'd0, 0); dec_valid = 0;
    clr_fwd();

    // vectors: forwarding priorities and ALU-control decode
    vecs.push_back('{64'd0,  64'd30, 64'd0, 5, 6, 1, c_r_sub, 3'b000, 1, 5, 64'd100, 0, 0, 64'd0, 64'd100, 64'd30, 64'd30, 4'b0110, 1});
    vecs.push_back('{64'd7,  64'd99, 64'd0, 1, 7, 2, c_r_add, 3'b000, 1, 7, 64'd11, 1, 7, 64'd22, 64'd7, 64'd11, 64'd11, 4'b0010, 1});
    vecs.push_back('{64'd3,  64'd4,  64'd0, 8, 2, 3, c_r_add, 3'b111, 1, 9, 64'd66, 1, 8, 64'd55, 64'd55, 64'd4, 64'd4, 4'b0000, 1});
    vecs.push_back('{64'd0,  64'd0,  64'd0, 0, 0, 4, c_r_add, 3'b110, 1, 0, 64'd77, 1, 0, 64'd88, 64'd0, 64'd0, 64'd0, 4'b0001, 1});
    vecs.push_back('{64'd50, 64'd9,  -64'sd4, 10, 3, 5, 9'b11_1_0_0_1_0_0_1, 3'b000, 0, 0, 64'd0, 0, 0, 64'd0, 64'd50, -64'sd4, 64'd9, 4'b0010, 1});
    vecs.push_back('{64'd1,  64'd2,  64'd0, 11, 12, 6, c_r_add, 3'b100, 0, 0, 64'd0, 0, 0, 64'd0, 64'd1, 64'd2, 64'd2, 4'b1111, 1});
    vecs.push_back('{64'd5,  64'd6,  64'd8, 11, 12, 7, 9'b11_1_0_0_1_0_0_0, 3'b111, 0, 0, 64'd0, 0, 0, 64'd0, 64'd5, 64'd8, 64'd6, 4'b0000, 1});
    vecs.push_back('{64'd5,  64'd6,  64'd8, 11, 12, 7, 9'b11_1_0_0_1_0_0_1, 3'b110, 0, 0, 64'd0, 0, 0, 64'd0, 64'd5, 64'd8, 64'd6, 4'b0001, 1});
    vecs.push_back('{64'd5,  64'd6,  64'd8, 11, 12, 7, 9'b11_1_0_0_1_0_0_0, 3'b001, 0, 0, 64'd0, 0, 0, 64'd0, 64'd5, 64'd8, 64'd6, 4'b1111, 1});
    vecs.push_back('{64'd5,  64'd6,  64'd16, 11, 12, 0, 9'b00_1_0_1_0_0_0_0, 3'b011, 1, 12, 64'd33, 0, 0, 64'd0, 64'd5, 64'd16, 64'd33, 4'b0010, 0});
    vecs.push_back('{64'd5,  64'd6,  64'd0, 11, 12, 0, 9'b01_0_0_0_0_0_1_0, 3'b000, 0, 0, 64'd0, 1, 11, 64'd44, 64'd44, 64'd6, 64'd6, 4'b0110, 0});

    // reset state
    #12;
    chk("reset_valid", ex_valid, 0);
    chk("reset_alu_control", alu_control, 4'b0010);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_reg_write", ex_reg_write, 0);
    @(negedge clk); rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      clr_fwd();
      dec_valid = 1; dec_pc = 64'h1000 + i; dec_uses_rs2 = 1;
      dec_rs1_data = vecs[i].rs1_data; dec_rs2_data = vecs[i].rs2_data; dec_imm = vecs[i].imm;
      dec_rs1 = vecs[i].rs1; dec_rs2 = vecs[i].rs2; dec_rd = vecs[i].rd;
      dec_ctrl = vecs[i].ctrl; dec_funct3 = vecs[i].f3;
      tick();
      exm_reg_write = vecs[i].exm_we; exm_rd = vecs[i].exm_rd; exm_result = vecs[i].exm_res;
      mwb_reg_write = vecs[i].mwb_we; mwb_rd = vecs[i].mwb_rd; mwb_result = vecs[i].mwb_res;
      #1;
      chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].exp_a);
      chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].exp_b);
      chk($sformatf("v%0d_store", i), ex_store_data, vecs[i].exp_store);
      chk($sformatf("v%0d_alu_ctl", i), alu_control, vecs[i].exp_ctl);
      chk($sformatf("v%0d_reg_write", i), ex_reg_write, vecs[i].exp_rw);
      chk($sformatf("v%0d_pc", i), ex_pc, 64'h1000 + i);
    end
    clr_fwd();

    // load-use: ld x3 in EX, decode add x4,x3,x1
    dec_set(7, 8, 3, c_ld, 1);
    tick();
    chk("ld_mem_read", ex_mem_read, 1);
    dec_set(9, 3, 4, c_r_add, 0);
    #1 chk("lu_rs2_unused", load_use_stall, 0);
    dec_set(3, 1, 4, c_r_add, 1);
    #1 chk("lu_detect", load_use_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rw", ex_reg_write, 0);
    chk("lu_released", load_use_stall, 0);
    tick();
    chk("lu_add_captured_rd", ex_rd, 4);
    chk("lu_add_valid", ex_valid, 1);

    // stall holds a load against a dependent decode; hazard persists
    dec_set(7, 8, 3, c_ld, 1);
    tick();
    dec_set(3, 1, 4, c_r_add, 1);
    stall = 1;
    tick();
    chk("stall_hold_rd", ex_rd, 3);
    chk("stall_hold_mr", ex_mem_read, 1);
    chk("stall_hazard_again", load_use_stall, 1);
    // flush masks the hazard and beats stall
    flush = 1;
    #1 chk("flush_masks_lu", load_use_stall, 0);
    tick();
    chk("flush_bubble_valid", ex_valid, 0);
    chk("flush_bubble_rw", ex_reg_write, 0);
    chk("flush_bubble_ctl", alu_control, 4'b0010);
    stall = 0; flush = 0;

    // stall alone holds a valid ALU op
    dec_set(2, 0, 9, c_r_sub, 1);
    tick();
    dec_set(2, 0, 10, c_r_add, 1);
    stall = 1;
    tick();
    chk("stall_keep_rd", ex_rd, 9);
    chk("stall_keep_ctl", alu_control, 4'b0110);
    stall = 0;

    // asynchronous reset mid-stream
    dec_set(5, 6, 11, c_r_sub, 1);
    tick();
    #2 rst_n = 0;
    #1;
    chk("mid_reset_valid", ex_valid, 0);
    chk("mid_reset_ctl", alu_control, 4'b0010);
    chk("mid_reset_a", alu_a, 0);
    chk("mid_reset_rd", ex_rd, 0);
    @(negedge clk); rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
